// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// default geometry (address width, instruction width, fetch timeout).
package fetch_pkg;

   localparam int DEF_SIZE    = 8;
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      ISSUE  = 3'd2,
      STEP   = 3'd3,
      SETTLE = 3'd4,
      DONE   = 3'd5
   } fetch_state_t;

   // Width of a down-counter that must hold the value n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read port and instruction hand-off port of the fetch sequencer.
// master: the sequencer; slave: the memory and the instruction consumer.
interface fetch_sequencer_if
   import fetch_pkg::*;
   #(
      parameter int SIZE  = DEF_SIZE,
      parameter int WIDTH = DEF_WIDTH
   );

   logic             mem_req;
   logic [SIZE-1:0]  mem_addr;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_data;

   logic [WIDTH-1:0] instr;
   logic             instr_valid;
   logic             instr_ready;

   modport master (
      output mem_req, mem_addr, instr, instr_valid,
      input  mem_ack, mem_data, instr_ready
   );

   modport slave (
      input  mem_req, mem_addr, instr, instr_valid,
      output mem_ack, mem_data, instr_ready
   );

endinterface

// File: rtl/fetch_timeout.sv
// Fetch watchdog: down-counter loaded with TIMEOUT while the sequencer is out
// of FETCH, decremented for every FETCH cycle without an ack. expired is high
// during the TIMEOUT-th unacknowledged cycle so the sequencer can abort at
// the end of it.
module fetch_timeout
   import fetch_pkg::*;
   #(
      parameter int TIMEOUT = DEF_TIMEOUT
   ) (
      input  logic clk,
      input  logic reset,
      input  logic clear,
      input  logic run,
      output logic expired
   );

   localparam int CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt;

   // Reload outside FETCH, count down while waiting for the ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= CW'(TIMEOUT);
      end else if (clear) begin
         cnt <= CW'(TIMEOUT);
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = run && (cnt == CW'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads the word at pc, hands it to the consumer,
// then pulses incr to advance the external program counter. Stops at the top
// address (done) or on halt sampled at the end of each step.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch whose ack does
// not arrive within TIMEOUT cycles (sets the sticky err flag).
//
// state  | meaning
// IDLE   | waiting for start; all handshake outputs low
// FETCH  | mem_req high, mem_addr = pc, waiting for mem_ack
// ISSUE  | instr_valid high, waiting for instr_ready
// STEP   | incr high for one cycle
// SETTLE | incr low for one cycle, pc updates; halt sampled on exit
// DONE   | top address issued; done held until reset
module fetch_sequencer
   import fetch_pkg::*;
   #(
      parameter int SIZE    = DEF_SIZE,
      parameter int WIDTH   = DEF_WIDTH,
      parameter int TIMEOUT = DEF_TIMEOUT
   ) (
      input  logic            clk,
      input  logic            reset,
      input  logic            start,
      input  logic            halt,
      input  logic [SIZE-1:0] pc,
      output logic            incr,
      output logic            done,
      output logic            err,
      fetch_sequencer_if.master bus
   );

   fetch_state_t state;
   logic         start_armed;
   logic         fetch_expired;

   // The watchdog counter is a plain down-counter; zero would never fire.
   if (TIMEOUT < 1) begin : g_timeout_range
      $error("fetch_sequencer: TIMEOUT must be at least 1");
   end

`ifdef FETCH_TIMEOUT_EN
   fetch_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != FETCH),
      .run     ((state == FETCH) && !bus.mem_ack),
      .expired (fetch_expired)
   );
`else
   assign fetch_expired = 1'b0;
`endif

   // Sequencer FSM; every output is a register so incr edges are glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         start_armed     <= 1'b1;
         incr            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         bus.mem_req     <= 1'b0;
         bus.mem_addr    <= '0;
         bus.instr       <= '0;
         bus.instr_valid <= 1'b0;
      end else begin
         // A level start launches one run; it must drop before the next one.
         if (!start) begin
            start_armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start && start_armed) begin
                  start_armed  <= 1'b0;
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= pc;
                  state        <= FETCH;
               end
            end

            FETCH: begin
               if (bus.mem_ack) begin
                  bus.instr       <= bus.mem_data;
                  bus.mem_req     <= 1'b0;
                  bus.instr_valid <= 1'b1;
                  state           <= ISSUE;
               end else if (fetch_expired) begin
                  bus.mem_req <= 1'b0;
                  err         <= 1'b1;
                  state       <= IDLE;
               end
            end

            ISSUE: begin
               if (bus.instr_ready) begin
                  bus.instr_valid <= 1'b0;
                  if (&pc) begin
                     // Top address: no step, the counter must not wrap.
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     incr  <= 1'b1;
                     state <= STEP;
                  end
               end
            end

            STEP: begin
               incr  <= 1'b0;
               state <= SETTLE;
            end

            SETTLE: begin
               if (halt) begin
                  state <= IDLE;
               end else begin
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= pc;
                  state        <= FETCH;
               end
            end

            DONE: begin
               state <= DONE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic reset, start, halt, start_b;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // ---------------- DUT A: default geometry ----------------
   logic [7:0]  pc_a, pc_init;
   logic        pc_load, incr_a, incr_a_q, done_a, err_a;
   int          ack_dly, rdy_dly, wcnt, vcnt;
   logic [15:0] mem_a [256];

   fetch_sequencer_if #(.SIZE(DEF_SIZE), .WIDTH(DEF_WIDTH)) aif ();

   fetch_sequencer #(.SIZE(DEF_SIZE), .WIDTH(DEF_WIDTH)) dut_a (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .halt  (halt),
      .pc    (pc_a),
      .incr  (incr_a),
      .done  (done_a),
      .err   (err_a),
      .bus   (aif)
   );

   // program counter: advances on each 0->1 of incr
   always @(posedge clk) begin
      incr_a_q <= incr_a;
      if (pc_load) pc_a <= pc_init;
      else if (incr_a && !incr_a_q) pc_a <= pc_a + 8'd1;
   end

   // memory: acks ack_dly cycles after the request is seen (0 = never)
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         aif.mem_ack <= 1'b0;
         wcnt        <= 0;
      end else begin
         aif.mem_ack  <= 1'b0;
         aif.mem_data <= 16'($urandom);
         if (aif.mem_req && !aif.mem_ack && ack_dly != 0) begin
            if (wcnt + 1 >= ack_dly) begin
               aif.mem_ack  <= 1'b1;
               aif.mem_data <= mem_a[aif.mem_addr];
               wcnt         <= 0;
            end else begin
               wcnt <= wcnt + 1;
            end
         end
      end
   end

   // consumer: ready after instr_valid has waited rdy_dly cycles
   always @(posedge clk or posedge reset) begin
      if (reset) vcnt <= 0;
      else if (aif.instr_valid && !aif.instr_ready) vcnt <= vcnt + 1;
      else vcnt <= 0;
   end
   assign aif.instr_ready = (rdy_dly == 0) || (vcnt >= rdy_dly);

   // ---------------- DUT B: SIZE=3 ----------------
   logic [2:0]  pc_b;
   logic        incr_b, incr_b_q, done_b, err_b;
   logic [15:0] mem_b [8];

   fetch_sequencer_if #(.SIZE(3), .WIDTH(DEF_WIDTH)) bif ();

   fetch_sequencer #(.SIZE(3), .WIDTH(DEF_WIDTH)) dut_b (
      .clk   (clk),
      .reset (reset),
      .start (start_b),
      .halt  (1'b0),
      .pc    (pc_b),
      .incr  (incr_b),
      .done  (done_b),
      .err   (err_b),
      .bus   (bif)
   );

   always @(posedge clk) begin
      incr_b_q <= incr_b;
      if (pc_load) pc_b <= 3'd0;
      else if (incr_b && !incr_b_q) pc_b <= pc_b + 3'd1;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) bif.mem_ack <= 1'b0;
      else begin
         bif.mem_ack  <= bif.mem_req && !bif.mem_ack;
         bif.mem_data <= mem_b[bif.mem_addr];
      end
   end
   assign bif.instr_ready = 1'b1;

   // ---------------- monitors ----------------
   int          cyc = 0;
   int          dbl_a = 0;
   int          unstable_a = 0;
   int          incr_b_cnt = 0;
   logic        prev_req = 1'b0, prev_valid = 1'b0, prev_incr = 1'b0, prev_incr_b = 1'b0;
   logic [7:0]  prev_addr = '0;
   logic [15:0] prev_instr = '0;
   logic [7:0]  xa [$];
   logic [15:0] xi [$];
   int          incr_cyc [$];
   logic [2:0]  xb_a [$];
   logic [15:0] xb_i [$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (aif.instr_valid && aif.instr_ready) begin
         xa.push_back(aif.mem_addr);
         xi.push_back(aif.instr);
      end
      if (incr_a && !prev_incr) incr_cyc.push_back(cyc);
      if (incr_a && prev_incr) dbl_a <= dbl_a + 1;
      if ((prev_req && aif.mem_req && aif.mem_addr !== prev_addr) ||
          (prev_valid && aif.instr_valid && aif.instr !== prev_instr))
         unstable_a <= unstable_a + 1;
      prev_req   <= aif.mem_req;
      prev_addr  <= aif.mem_addr;
      prev_valid <= aif.instr_valid;
      prev_instr <= aif.instr;
      prev_incr  <= incr_a;
      if (bif.instr_valid && bif.instr_ready) begin
         xb_a.push_back(bif.mem_addr);
         xb_i.push_back(bif.instr);
      end
      if (incr_b && !prev_incr_b) incr_b_cnt <= incr_b_cnt + 1;
      prev_incr_b <= incr_b;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      xa.delete();
      xi.delete();
      incr_cyc.delete();
   endtask

   // One run of n instructions from p0, stopped by halt after the n-th one.
   task automatic run_burst(input int p0, input int ad, input int rd, input int n);
      int d0, u0, sp;
      ack_dly = ad;
      rdy_dly = rd;
      pc_init = 8'(p0);
      pc_load = 1'b1;
      tick();
      pc_load = 1'b0;
      clear_logs();
      d0 = dbl_a;
      u0 = unstable_a;
      sp = (ad + 1) + (rd + 1) + 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40 * n && xa.size() < n; i++) tick();
      halt = 1'b1;
      repeat (4) tick();
      halt = 1'b0;
      chk("burst_xfers", xa.size(), n);
      for (int k = 0; k < n && k < xa.size(); k++) begin
         chk("burst_addr", {24'd0, xa[k]}, p0 + k);
         chk("burst_instr", {16'd0, xi[k]}, {16'd0, mem_a[p0 + k]});
      end
      chk("burst_incr_cnt", incr_cyc.size(), n);
      for (int k = 1; k < incr_cyc.size(); k++)
         chk("burst_incr_spacing", incr_cyc[k] - incr_cyc[k-1], sp);
      chk("burst_incr_width", dbl_a - d0, 0);
      chk("burst_stable", unstable_a - u0, 0);
      chk("burst_pc_end", {24'd0, pc_a}, p0 + n);
      chk("burst_req_idle", {31'd0, aif.mem_req}, 0);
      chk("burst_valid_idle", {31'd0, aif.instr_valid}, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem_a[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) mem_b[i] = 16'($urandom);
      reset = 1'b1; start = 1'b0; halt = 1'b0; start_b = 1'b0;
      ack_dly = 1; rdy_dly = 0; pc_init = 8'd0; pc_load = 1'b1;
      repeat (3) tick();

      // reset values
      chk("rst_incr", {31'd0, incr_a}, 0);
      chk("rst_mem_req", {31'd0, aif.mem_req}, 0);
      chk("rst_valid", {31'd0, aif.instr_valid}, 0);
      chk("rst_done", {31'd0, done_a}, 0);
      chk("rst_err", {31'd0, err_a}, 0);
      chk("rst_addr", {24'd0, aif.mem_addr}, 0);
      chk("rst_instr", {16'd0, aif.instr}, 0);
      pc_load = 1'b0;
      reset = 1'b0;
      tick();

      // four words, immediate ack/ready, then slow ack/ready continuing at 4
      run_burst(0, 1, 0, 4);
      run_burst(4, 3, 2, 3);
      for (int r = 0; r < 3; r++)
         run_burst($urandom_range(8, 200), $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(2, 4));

      // halt during ISSUE of address 2 with start held high
      reset = 1'b1; pc_init = 8'd0; pc_load = 1'b1; ack_dly = 1; rdy_dly = 1;
      tick(); tick();
      pc_load = 1'b0; reset = 1'b0;
      clear_logs();
      start = 1'b1;
      for (int i = 0; i < 100 && !(aif.instr_valid && aif.mem_addr == 8'd2); i++) tick();
      chk("halt_reach_issue2", {31'd0, aif.instr_valid && aif.mem_addr == 8'd2}, 1);
      halt = 1'b1;
      repeat (6) tick();
      chk("halt_pc", {24'd0, pc_a}, 3);
      chk("halt_req_idle", {31'd0, aif.mem_req}, 0);
      chk("halt_xfers", xa.size(), 3);
      chk("halt_incr_cnt", incr_cyc.size(), 3);
      repeat (5) tick();
      chk("held_start_no_rerun", {31'd0, aif.mem_req}, 0);
      halt = 1'b0; start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && xa.size() < 4; i++) tick();
      chk("resume_xfers", xa.size(), 4);
      if (xa.size() >= 4) begin
         chk("resume_addr", {24'd0, xa[3]}, 3);
         chk("resume_instr", {16'd0, xi[3]}, {16'd0, mem_a[3]});
      end

      // reset in the middle of STEP
      for (int i = 0; i < 100 && !incr_a; i++) tick();
      chk("step_reached", {31'd0, incr_a}, 1);
      reset = 1'b1;
      #1;
      chk("step_rst_incr", {31'd0, incr_a}, 0);
      chk("step_rst_req", {31'd0, aif.mem_req}, 0);
      chk("step_rst_valid", {31'd0, aif.instr_valid}, 0);
      chk("step_rst_addr", {24'd0, aif.mem_addr}, 0);
      chk("step_rst_instr", {16'd0, aif.instr}, 0);
      chk("step_rst_done", {31'd0, done_a}, 0);
      tick(); tick();
      reset = 1'b0;
      repeat (4) tick();
      chk("step_rst_idle", {31'd0, aif.mem_req}, 0);

      // SIZE=3 instance runs the whole space and stops at 7
      pc_load = 1'b1;
      tick();
      pc_load = 1'b0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 100 && !done_b; i++) tick();
      chk("b_done", {31'd0, done_b}, 1);
      chk("b_xfers", xb_a.size(), 8);
      for (int k = 0; k < xb_a.size() && k < 8; k++) begin
         chk("b_addr", {29'd0, xb_a[k]}, k);
         chk("b_instr", {16'd0, xb_i[k]}, {16'd0, mem_b[k]});
      end
      chk("b_incr_cnt", incr_b_cnt, 7);
      start_b = 1'b1;
      repeat (6) tick();
      start_b = 1'b0;
      chk("b_done_held", {31'd0, done_b}, 1);
      chk("b_req_low", {31'd0, bif.mem_req}, 0);
      chk("b_pc_final", {29'd0, pc_b}, 7);
      chk("b_no_refetch", xb_a.size(), 8);
      chk("b_incr_final", incr_b_cnt, 7);

`ifdef FETCH_TIMEOUT_EN
      // memory never acks: watchdog aborts the fetch
      reset = 1'b1; ack_dly = 0;
      tick();
      reset = 1'b0;
      clear_logs();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         if (aif.mem_req) n++;
         else if (n > 0) break;
         tick();
      end
      chk("to_req_cycles", n, DEF_TIMEOUT);
      chk("to_err", {31'd0, err_a}, 1);
      chk("to_req_low", {31'd0, aif.mem_req}, 0);
      chk("to_no_incr", incr_cyc.size(), 0);
      repeat (3) tick();
      chk("to_err_sticky", {31'd0, err_a}, 1);
      chk("to_idle", {31'd0, aif.mem_req}, 0);
`else
      n = 0;
      chk("err_tied_a", {31'd0, err_a}, n);
      chk("err_tied_b", {31'd0, err_b}, n);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter SIZE, default 8: address width, equal to the program-counter width.
REQ-002 Parameter WIDTH, default 16: instruction word width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles to wait for mem_ack; used only when FETCH_TIMEOUT_EN is defined.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  level; starts fetching from IDLE.
REQ-007 halt  input  1  level; stops the sequence at the next step boundary.
REQ-008 pc  input  SIZE  current program-counter value.
REQ-009 incr  output  1  step request to the program counter, registered; the counter advances on a 0->1 transition.
REQ-010 mem_req  output  1  memory read request.
REQ-011 mem_addr  output  SIZE  read address.
REQ-012 mem_ack  input  1  read data valid this cycle.
REQ-013 mem_data  input  WIDTH  read data.
REQ-014 instr  output  WIDTH  fetched instruction.
REQ-015 instr_valid  output  1  instr is presented to the consumer.
REQ-016 instr_ready  input  1  consumer accepts instr.
REQ-017 done  output  1  sticky; the last address has been issued.
REQ-018 err  output  1  sticky; a fetch timed out.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, ISSUE, STEP, SETTLE, DONE.
- IDLE: all handshake outputs low.
- IDLE -> FETCH when start=1.
REQ-020 FETCH, request phase:
- mem_req=1 and mem_addr=pc, held stable until mem_ack=1.
- On mem_ack: capture mem_data into instr, drop mem_req the next cycle, go to ISSUE.
REQ-021 ISSUE, consumer handshake:
- instr_valid=1, instr held stable until instr_ready=1.
- Transfer occurs in the cycle where instr_valid and instr_ready are both 1; instr_valid=0 the following cycle.
REQ-022 After a transfer:
- pc = 2^SIZE-1 -> DONE (no incr, no wrap).
- Otherwise -> STEP.
REQ-023 STEP: incr=1 for exactly one cycle, then SETTLE.
REQ-024 SETTLE: incr=0 for exactly one cycle, guaranteeing a fresh 0->1 edge on every step; the updated pc is valid at SETTLE exit.
REQ-025 SETTLE exit:
- halt=1 -> IDLE.
- Otherwise -> FETCH with the new pc.
- halt has no effect in any other state.
REQ-026 Exactly one incr pulse SHALL occur per accepted instruction; incr is never high in two consecutive cycles.
REQ-027 DONE: done=1 held, all other handshake outputs 0; DONE is left only by reset.
REQ-028 A start held high in IDLE SHALL begin exactly one run; start is ignored outside IDLE.
REQ-029 Minimum cycles per instruction with immediate ack and ready SHALL be 5 (FETCH, ack, ISSUE, STEP, SETTLE).

Reset
REQ-030 On reset=1 the FSM SHALL enter IDLE immediately, with incr, mem_req, instr_valid, done and err all 0; mem_addr=0 and instr=0.
REQ-031 Reset during FETCH or ISSUE SHALL abandon the transaction with no incr pulse; reset during STEP SHALL force incr low at once.

Configuration
REQ-032 Macro FETCH_TIMEOUT_EN, when defined: a counter runs while in FETCH with mem_ack=0.
- On reaching TIMEOUT: mem_req drops, err is set (sticky until reset), FSM goes to IDLE with no incr pulse.
- The counter clears whenever FETCH is entered.
REQ-033 Without FETCH_TIMEOUT_EN: FETCH waits indefinitely and err is tied to 0.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enumeration and the default SIZE, WIDTH and TIMEOUT constants.
REQ-035 The timeout counter SHALL be a sub-module fetch_timeout, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-036 Bench SHALL pair the block with a program counter and a memory model.
REQ-037 Reset, start, 4 words, immediate ack and ready:
- mem_addr 0,1,2,3 in order.
- instr matches memory.
- 4 incr pulses, each 1 cycle wide and spaced 5 cycles.
REQ-038 Ack delay 3 cycles and ready delay 2 cycles:
- mem_addr and instr stay stable while waiting.
- Exactly one incr per instruction.
REQ-039 halt raised during ISSUE of address 2:
- FSM returns to IDLE after SETTLE, pc=3.
- A new start resumes fetching at address 3.
REQ-040 SIZE=3, run from pc=0: 8 fetches, 7 incr pulses, done=1 after address 7; pc stays 7.
REQ-041 Reset asserted in the middle of STEP: incr low within the same cycle, all outputs 0, FSM in IDLE.
REQ-042 With FETCH_TIMEOUT_EN and mem_ack never asserted: err=1 and mem_req=0 after 15 cycles, no incr pulse, FSM in IDLE.
